mul_share_arb: RTL and testbench

Round-robin scheduler that shares one combinational 4x4 signed (two's-complement) array multiplier among NUM_REQ requesters. It sits between the requester ports and the multiplier instance. It grants one request at a time, holds the operands stable on the multiplier inputs for a settle cycle, and registers the 8-bit product. It then returns the product with the requester's ID over a valid/ready response port.

---
 rtl/mul_share_arb_pkg.sv | 16 +
 rtl/mul_share_arb_if.sv | 31 +++
 rtl/mul_share_arb_rr.sv | 39 +++
 rtl/mul_share_arb.sv | 91 +++++++++
 tb/tb_mul_share_arb.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_share_arb_pkg.sv
// Shared types and widths for the mul_share_arb slice.
//   state_t : scheduler FSM states (IDLE, MUL, RESP)
//   OP_W    : signed operand width fed to the multiplier
//   PROD_W  : full-precision signed product width
package mul_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned PROD_W = 8;

endpackage

// File: rtl/mul_share_arb_if.sv
// Requester / response bus of mul_share_arb.
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_a/req_b         : packed signed operands, requester i at [4i+3:4i]
//   rsp_valid/rsp_ready : response handshake
//   rsp_id/rsp_p        : owner index and signed product
// Modports: slave = scheduler side, master = requesters plus consumer.
interface mul_share_arb_if
    import mul_share_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [OP_W*NUM_REQ-1:0] req_a;
    logic [OP_W*NUM_REQ-1:0] req_b;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [PROD_W-1:0]       rsp_p;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_p
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_p
    );
endinterface

// File: rtl/mul_share_arb_rr.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : highest-priority index this cycle
//   gnt : one-hot grant (zero when no request)
//   idx : encoded grant index
//   any : at least one request present
module rr_arb_onehot #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;

    always_comb begin
        // Rotate so ptr lands at bit 0, then a fixed-priority scan finds the
        // first requester at or after ptr with wrap.
        dbl = {req, req} >> ptr;
        rot = dbl[N-1:0];
        off = '0;
        for (int unsigned k = N; k > 0; k--) begin
            if (rot[k-1]) begin
                off = IW'(k - 1);
            end
        end
        any = |req;
        sum = {1'b0, ptr} + {1'b0, off};
        idx = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
        gnt = '0;
        gnt[idx] = any;
    end
endmodule

// File: rtl/mul_share_arb.sv
// Round-robin scheduler sharing one external 4x4 signed multiplier.
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus (slave)    : requester handshake/operands and response port
//   mul_a, mul_b   : registered operands to the multiplier
//   mul_p          : product returned by the multiplier
//   busy           : high whenever not idle
//   op_count       : completed response handshakes, wraps silently
module mul_share_arb
    import mul_share_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    mul_share_arb_if.slave    bus,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic [PROD_W-1:0] mul_p,
    output logic              busy,
    output logic [15:0]       op_count
);
    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     id_q;
    logic [ID_W-1:0]     g_idx;
    logic [NUM_REQ-1:0]  g_onehot;
    logic                g_any;

    rr_arb_onehot #(.N(NUM_REQ), .IW(ID_W)) u_arb (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .gnt (g_onehot),
        .idx (g_idx),
        .any (g_any)
    );

    // Grant is only offered while idle; gating with rst_n keeps it zero
    // during reset even though the FSM already sits in IDLE.
    always_comb begin
        bus.req_ready = '0;
        if (rst_n && state == IDLE) begin
            bus.req_ready = g_onehot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            id_q          <= '0;
            mul_a         <= '0;
            mul_b         <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_p     <= '0;
            busy          <= 1'b0;
            op_count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (g_any) begin
                        mul_a  <= bus.req_a[g_idx*OP_W +: OP_W];
                        mul_b  <= bus.req_b[g_idx*OP_W +: OP_W];
                        id_q   <= g_idx;
                        rr_ptr <= (32'(g_idx) == NUM_REQ - 1) ? '0 : g_idx + 1'b1;
                        busy   <= 1'b1;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    bus.rsp_p     <= mul_p;
                    bus.rsp_id    <= id_q;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        op_count      <= op_count + 16'd1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_share_arb.sv
// Scoreboard bench for mul_share_arb with an external behavioural multiplier.
module tb_mul_share_arb;
    import mul_share_pkg::*;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = $clog2(NUM_REQ);

    logic        clk;
    logic        rst_n;
    logic [3:0]  mul_a, mul_b;
    logic [7:0]  mul_p;
    logic        busy;
    logic [15:0] op_count;

    mul_share_arb_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    mul_share_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_p    (mul_p),
        .busy     (busy),
        .op_count (op_count)
    );

    // External combinational signed multiplier
    logic signed [7:0] xa, xb;
    assign xa    = 8'($signed(mul_a));
    assign xb    = 8'($signed(mul_b));
    assign mul_p = xa * xb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int unsigned id;
        logic [7:0]  p;
    } exp_t;
    exp_t sbq[$];

    // Requester-side state and reference model
    bit          pend [NUM_REQ];
    logic [3:0]  pa   [NUM_REQ];
    logic [3:0]  pb   [NUM_REQ];
    int unsigned m_ptr  = 0;
    bit          m_free = 1'b1;
    int          m_gcyc = 0;
    logic [3:0]  m_a = '0, m_b = '0;
    logic [15:0] m_ops = '0;
    int          cyc = 0;
    int unsigned p_new = 0;
    int unsigned p_rdy = 100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [7:0] prod(input logic [3:0] a, input logic [3:0] b);
        int r;
        r = int'($signed(a)) * int'($signed(b));
        return r[7:0];
    endfunction

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_valid[i]       = pend[i];
            bus.req_a[4*i +: 4]    = pa[i];
            bus.req_b[4*i +: 4]    = pb[i];
        end
    endtask

    task automatic issue(input int i, input logic [3:0] a, input logic [3:0] b);
        pend[i] = 1'b1;
        pa[i]   = a;
        pb[i]   = b;
        drive();
    endtask

    // One clock: check at negedge against the model, then update stimulus
    // just after the following posedge.
    task automatic tick();
        logic [NUM_REQ-1:0] exp_rdy;
        bit exp_rv;
        int g;
        @(negedge clk);
        exp_rdy = '0;
        g = -1;
        if (m_free) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int i;
                i = int'((m_ptr + k) % NUM_REQ);
                if (pend[i] && g < 0) g = i;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        exp_rv = !m_free && (cyc >= m_gcyc + 2);
        check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
        check("busy", 32'(busy), 32'(!m_free));
        check("op_count", 32'(op_count), 32'(m_ops));
        if (!m_free) begin
            check("mul_a", 32'(mul_a), 32'(m_a));
            check("mul_b", 32'(mul_b), 32'(m_b));
        end
        if (g >= 0) begin
            sbq.push_back('{id: g, p: prod(pa[g], pb[g])});
            pend[g] = 1'b0;
            m_a     = pa[g];
            m_b     = pb[g];
            m_ptr   = (g + 1) % NUM_REQ;
            m_free  = 1'b0;
            m_gcyc  = cyc;
        end else if (exp_rv && bus.rsp_ready) begin
            m_free = 1'b1;
            m_ops  = m_ops + 16'd1;
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pend[i] && $urandom_range(99) < p_new) begin
                pend[i] = 1'b1;
                pa[i]   = 4'($urandom);
                pb[i]   = 4'($urandom);
            end
        end
        bus.rsp_ready = ($urandom_range(99) < p_rdy);
        drive();
    endtask

    task automatic model_reset();
        sbq.delete();
        m_free = 1'b1;
        m_ptr  = 0;
        m_ops  = '0;
    endtask

    // Abort an operation with reset after `extra` cycles beyond the grant
    task automatic abort_after(input int extra);
        p_new = 0;
        p_rdy = 0;
        issue(1, 4'h3, 4'h4);
        for (int t = 0; t < 4 && m_free; t++) tick();
        for (int t = 0; t < extra; t++) tick();
        rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_req_ready", 32'(bus.req_ready), 32'd0);
        check("abort_op_count", 32'(op_count), 32'd0);
        model_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            pend[i] = 1'b1;
            pa[i]   = 4'($urandom);
            pb[i]   = 4'($urandom);
        end
        p_rdy = 100;
        bus.rsp_ready = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int t = 0; t < 16; t++) tick();
    endtask

    // Response monitor: compares whatever the DUT presents with the queue head
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid) begin
            if (sbq.size() == 0) begin
                check("rsp_stale", 32'(bus.rsp_valid), 32'd0);
            end else begin
                check("rsp_id", 32'(bus.rsp_id), sbq[0].id);
                check("rsp_p", 32'(bus.rsp_p), 32'(sbq[0].p));
                if (bus.rsp_ready) void'(sbq.pop_front());
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pend[i] = 1'b0;
            pa[i]   = '0;
            pb[i]   = '0;
        end
        #3;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_mul_a", 32'(mul_a), 32'd0);
        check("rst_mul_b", 32'(mul_b), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("rst_rsp_p", 32'(bus.rsp_p), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);

        // All requesters valid from reset, consumer always ready
        p_new = 100;
        p_rdy = 100;
        for (int i = 0; i < NUM_REQ; i++) begin
            pend[i] = 1'b1;
            pa[i]   = 4'($urandom);
            pb[i]   = 4'($urandom);
        end
        bus.rsp_ready = 1'b1;
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int t = 0; t < 16; t++) tick();
        p_new = 0;
        for (int t = 0; t < 16; t++) tick();

        // Single request from requester 2: -3 * 5
        issue(2, 4'hD, 4'h5);
        for (int t = 0; t < 5; t++) tick();

        // Corner operands
        issue(1, 4'h8, 4'h8);
        for (int t = 0; t < 4; t++) tick();
        issue(1, 4'h8, 4'h7);
        for (int t = 0; t < 4; t++) tick();
        issue(1, 4'h7, 4'h7);
        for (int t = 0; t < 4; t++) tick();
        issue(1, 4'h0, 4'h8);
        for (int t = 0; t < 4; t++) tick();

        // Back-pressure: response held while another request waits
        p_rdy = 0;
        bus.rsp_ready = 1'b0;
        issue(3, 4'h6, 4'hB);
        tick();
        issue(0, 4'h2, 4'h9);
        for (int t = 0; t < 11; t++) tick();
        p_rdy = 100;
        for (int t = 0; t < 8; t++) tick();

        // Random traffic with random back-pressure
        p_new = 30;
        p_rdy = 60;
        for (int t = 0; t < 400; t++) tick();
        p_new = 0;
        p_rdy = 100;
        for (int t = 0; t < 20; t++) tick();

        // Reset during MUL, then during RESP
        abort_after(0);
        abort_after(1);
        p_new = 0;
        p_rdy = 100;
        for (int t = 0; t < 20; t++) tick();

        // op_count wrap: preload the counter, complete one operation
        force dut.op_count = 16'hFFFF;
        #1;
        release dut.op_count;
        m_ops = 16'hFFFF;
        issue(0, 4'h5, 4'hE);
        for (int t = 0; t < 6; t++) tick();
        check("wrap_op_count", 32'(op_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
